escritor_de_instrucoes: RTL

Serializes 32-bit instruction words into the text program-file format consumed by the instruction memory. Each word becomes one line of 32 ASCII '0'/'1' characters, MSB first, followed by a terminator byte, so a line is exactly 33 bytes. The block sits between the program generator (assembler/test stimulus) and the file/byte sink. It tracks the file byte offset so that word k always starts at byte 33·k, which corresponds to instruction byte address 4·k.

---
 rtl/escritor_de_instrucoes_if.sv | 28 ++
 rtl/escritor_de_instrucoes.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/escritor_de_instrucoes_if.sv
// Handshake and status bundle between the program generator, the serializer and the byte sink.
interface escritor_de_instrucoes_if;
    logic        palavra_valida;
    logic [31:0] palavra;
    logic        palavra_pronta;
    logic        fim;
    logic        byte_valido;
    logic [7:0]  byte_dado;
    logic        byte_pronto;
    logic [31:0] endereco_byte;
    logic [31:0] palavras_escritas;
    logic        cheio;
    logic        concluido;

    // Producer/sink side.
    modport master (
        output palavra_valida, palavra, fim, byte_pronto,
        input  palavra_pronta, byte_valido, byte_dado, endereco_byte,
        input  palavras_escritas, cheio, concluido
    );

    // Serializer side.
    modport slave (
        input  palavra_valida, palavra, fim, byte_pronto,
        output palavra_pronta, byte_valido, byte_dado, endereco_byte,
        output palavras_escritas, cheio, concluido
    );
endinterface

// File: rtl/escritor_de_instrucoes.sv
// Serializes 32-bit instruction words into 33-byte text lines ('0'/'1' MSB first plus terminator),
// tracking the file byte offset and the number of complete lines written.
module escritor_de_instrucoes #(
    parameter logic [7:0]  TERMINADOR   = 8'h0A,
    parameter int unsigned MAX_PALAVRAS = 256
) (
    input logic                     clock,
    input logic                     reset,
    escritor_de_instrucoes_if.slave bus
);

    typedef enum logic [1:0] {StOcioso, StBits, StTerminador, StConcluido} estado_e;

    estado_e     estado_q, estado_d;
    logic [31:0] desloc_q, desloc_d;
    logic [4:0]  indice_q, indice_d;
    logic        fim_latch_q, fim_latch_d;
    logic        palavra_pronta_q, palavra_pronta_d;
    logic        byte_valido_q, byte_valido_d;
    logic [7:0]  byte_dado_q, byte_dado_d;
    logic [31:0] endereco_q, endereco_d;
    logic [31:0] palavras_q, palavras_d;
    logic        cheio_q, cheio_d;
    logic        concluido_q, concluido_d;

    logic fim_efetivo;
    logic transf_palavra;
    logic transf_byte;

    function automatic logic [7:0] caractere(input logic b);
        return b ? 8'h31 : 8'h30;
    endfunction

    // Next-state and next-output computation for the serializer FSM.
    always_comb begin
        estado_d         = estado_q;
        desloc_d         = desloc_q;
        indice_d         = indice_q;
        palavra_pronta_d = palavra_pronta_q;
        byte_valido_d    = byte_valido_q;
        byte_dado_d      = byte_dado_q;
        endereco_d       = endereco_q;
        palavras_d       = palavras_q;
        cheio_d          = cheio_q;
        concluido_d      = concluido_q;

        // fim seen this cycle counts as already latched, so no cycle of fim is lost.
        fim_efetivo    = fim_latch_q | bus.fim;
        fim_latch_d    = fim_efetivo;
        transf_palavra = bus.palavra_valida & palavra_pronta_q;
        transf_byte    = byte_valido_q & bus.byte_pronto;

        unique case (estado_q)
            StOcioso: begin
                if (transf_palavra) begin
                    // Word wins over a simultaneous fim; fim stays latched for later.
                    estado_d         = StBits;
                    desloc_d         = bus.palavra;
                    indice_d         = 5'd31;
                    palavra_pronta_d = 1'b0;
                    byte_valido_d    = 1'b1;
                    byte_dado_d      = caractere(bus.palavra[31]);
                end else if (fim_efetivo) begin
                    estado_d         = StConcluido;
                    palavra_pronta_d = 1'b0;
                    concluido_d      = 1'b1;
                end else begin
                    palavra_pronta_d = ~cheio_q;
                end
            end
            StBits: begin
                if (transf_byte) begin
                    endereco_d = endereco_q + 32'd1;
                    desloc_d   = desloc_q << 1;
                    if (indice_q == 5'd0) begin
                        estado_d    = StTerminador;
                        byte_dado_d = TERMINADOR;
                    end else begin
                        indice_d    = indice_q - 5'd1;
                        byte_dado_d = caractere(desloc_d[31]);
                    end
                end
            end
            StTerminador: begin
                if (transf_byte) begin
                    endereco_d    = endereco_q + 32'd1;
                    palavras_d    = palavras_q + 32'd1;
                    cheio_d       = (palavras_d == 32'(MAX_PALAVRAS));
                    byte_valido_d = 1'b0;
                    byte_dado_d   = 8'h00;
                    if (fim_efetivo) begin
                        estado_d    = StConcluido;
                        concluido_d = 1'b1;
                    end else begin
                        estado_d         = StOcioso;
                        palavra_pronta_d = ~cheio_d;
                    end
                end
            end
            StConcluido: begin
                palavra_pronta_d = 1'b0;
                byte_valido_d    = 1'b0;
                concluido_d      = 1'b1;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q         <= StOcioso;
            desloc_q         <= 32'd0;
            indice_q         <= 5'd0;
            fim_latch_q      <= 1'b0;
            palavra_pronta_q <= 1'b0;
            byte_valido_q    <= 1'b0;
            byte_dado_q      <= 8'h00;
            endereco_q       <= 32'd0;
            palavras_q       <= 32'd0;
            cheio_q          <= 1'b0;
            concluido_q      <= 1'b0;
        end else begin
            estado_q         <= estado_d;
            desloc_q         <= desloc_d;
            indice_q         <= indice_d;
            fim_latch_q      <= fim_latch_d;
            palavra_pronta_q <= palavra_pronta_d;
            byte_valido_q    <= byte_valido_d;
            byte_dado_q      <= byte_dado_d;
            endereco_q       <= endereco_d;
            palavras_q       <= palavras_d;
            cheio_q          <= cheio_d;
            concluido_q      <= concluido_d;
        end
    end

    assign bus.palavra_pronta    = palavra_pronta_q;
    assign bus.byte_valido       = byte_valido_q;
    assign bus.byte_dado         = byte_dado_q;
    assign bus.endereco_byte     = endereco_q;
    assign bus.palavras_escritas = palavras_q;
    assign bus.cheio             = cheio_q;
    assign bus.concluido         = concluido_q;

endmodule
